ex_muldiv: RTL and testbench

Iterative RV32M multiply/divide unit for the EX stage. It sits beside the single-cycle `alu` and is parametrised in operand width and bits retired per cycle. It accepts one M-extension operation from the ID/EX buffer and holds the pipeline through `stall_o` while it iterates. It returns a result with a one-cycle `done_o` pulse, and supports flush and early-out on divide special cases.

---
 rtl/rv32i_types.sv | 57 +++++
 rtl/ex_muldiv.sv | 188 ++++++++++++++++++
 tb/tb_ex_muldiv.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// Shared RV32 types for the EX-stage units.
//   muldiv_op_t    : M-extension funct3 encodings
//   muldiv_state_t : ex_muldiv control states
//   helpers        : op classification used at operand-latch and fixup time
package rv32i_types;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_t;

  typedef enum logic [2:0] {
    MD_IDLE,
    MD_MUL,
    MD_DIV,
    MD_FIXUP,
    MD_DONE
  } muldiv_state_t;

  function automatic logic op_is_div(input muldiv_op_t op);
    case (op)
      OP_DIV, OP_DIVU, OP_REM, OP_REMU: return 1'b1;
      default:                          return 1'b0;
    endcase
  endfunction

  // Quotient-returning divides; the others return the remainder.
  function automatic logic op_is_quot(input muldiv_op_t op);
    case (op)
      OP_DIV, OP_DIVU: return 1'b1;
      default:         return 1'b0;
    endcase
  endfunction

  // MUL only uses the low word, which is sign-agnostic, so treating it as
  // signed is harmless.
  function automatic logic op_a_signed(input muldiv_op_t op);
    case (op)
      OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM: return 1'b1;
      default:                                    return 1'b0;
    endcase
  endfunction

  function automatic logic op_b_signed(input muldiv_op_t op);
    case (op)
      OP_MUL, OP_MULH, OP_DIV, OP_REM: return 1'b1;
      default:                         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Magnitude shift-add multiply and restoring divide, BITS_PER_CYCLE bits per
// cycle, with sign fixup in a dedicated cycle. Divide-by-zero and signed
// overflow can complete in one cycle when EARLY_OUT is set.
// Ports:
//   clk, rst   : clock, asynchronous active-low reset
//   start_i    : M-extension op present in EX (sampled only in IDLE)
//   op_i       : funct3 of the op
//   a_i, b_i   : rs1 / rs2 after forwarding
//   flush_i    : redirect; kills the current op without a done pulse
//   stall_o    : freeze IF/ID/EX while the op is in flight
//   done_o     : one-cycle result-valid pulse
//   result_o   : result, held until the next accepted op completes
module ex_muldiv
  import rv32i_types::*;
#(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BITS_PER_CYCLE = 1,
  parameter bit          EARLY_OUT      = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int unsigned N  = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CW = $clog2(N) + 1;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CW-1:0]    LAST_IT = CW'(N - 1);

  muldiv_state_t      state_q, state_d;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   dsr_q;
  logic               sign_a_q, sign_b_q;
  logic               div_zero_q, div_ovf_q;
  muldiv_op_t         op_q;

  // Latch-time decode
  muldiv_op_t       op_in;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             in_div, in_zero, in_ovf, early;
  logic [WIDTH-1:0] early_res;
  logic             accept;

  always_comb begin
    op_in     = muldiv_op_t'(op_i);
    a_neg     = op_a_signed(op_in) & a_i[WIDTH-1];
    b_neg     = op_b_signed(op_in) & b_i[WIDTH-1];
    a_mag     = a_neg ? -a_i : a_i;
    b_mag     = b_neg ? -b_i : b_i;
    in_div    = op_is_div(op_in);
    in_zero   = in_div && (b_i == '0);
    in_ovf    = in_div && op_b_signed(op_in) && (a_i == MIN_VAL) && (b_i == '1);
    early     = EARLY_OUT && (in_zero || in_ovf);
    early_res = '0;
    if (in_zero)
      early_res = op_is_quot(op_in) ? '1 : a_i;
    else if (op_is_quot(op_in))
      early_res = MIN_VAL;
    accept    = (state_q == MD_IDLE) && start_i && !flush_i;
  end

  // Iteration datapath. Multiply keeps the multiplier in the low half and
  // shifts the partial product in from the top (the carry of the add lands in
  // the MSB). Divide shifts the dividend left into the remainder half and sets
  // the quotient bit in the LSB when the trial subtraction does not borrow.
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH:0]     sum, hi, diff;

  always_comb begin
    acc_step = acc_q;
    sum      = '0;
    hi       = '0;
    diff     = '0;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      if (state_q == MD_MUL) begin
        sum      = {1'b0, acc_step[2*WIDTH-1:WIDTH]}
                 + (acc_step[0] ? {1'b0, dsr_q} : '0);
        acc_step = {sum, acc_step[WIDTH-1:1]};
      end else begin
        hi   = acc_step[2*WIDTH-1:WIDTH-1];
        diff = hi - {1'b0, dsr_q};
        if (!diff[WIDTH])
          acc_step = {diff[WIDTH-1:0], acc_step[WIDTH-2:0], 1'b1};
        else
          acc_step = {hi[WIDTH-1:0], acc_step[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Sign fixup and result select
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem, fix_res;

  always_comb begin
    prod = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
    quo  = acc_q[WIDTH-1:0];
    rem  = acc_q[2*WIDTH-1:WIDTH];
    if (sign_a_q ^ sign_b_q)
      quo = -quo;
    if (sign_a_q)
      rem = -rem;
    // Restoring divide by zero already leaves the dividend as remainder;
    // only the quotient sign needs pinning. Overflow is forced outright.
    if (div_zero_q)
      quo = '1;
    if (div_ovf_q) begin
      quo = MIN_VAL;
      rem = '0;
    end
    if (op_is_div(op_q))
      fix_res = op_is_quot(op_q) ? quo : rem;
    else
      fix_res = (op_q == OP_MUL) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
  end

  // Next state and combinational outputs
  always_comb begin
    state_d = state_q;
    case (state_q)
      MD_IDLE: begin
        if (start_i && !flush_i) begin
          if (early)       state_d = MD_DONE;
          else if (in_div) state_d = MD_DIV;
          else             state_d = MD_MUL;
        end
      end
      MD_MUL, MD_DIV: begin
        if (cnt_q == LAST_IT)
          state_d = MD_FIXUP;
      end
      MD_FIXUP: state_d = MD_DONE;
      MD_DONE:  state_d = MD_IDLE;
      default:  state_d = MD_IDLE;
    endcase
    if (flush_i)
      state_d = MD_IDLE;
  end

  // Gated by rst so the pipeline is released as soon as reset asserts.
  assign stall_o = rst && (accept || (state_q == MD_MUL) || (state_q == MD_DIV)
                           || (state_q == MD_FIXUP));
  assign done_o  = (state_q == MD_DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= MD_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      dsr_q      <= '0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      div_zero_q <= 1'b0;
      div_ovf_q  <= 1'b0;
      op_q       <= OP_MUL;
      result_o   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q       <= op_in;
        sign_a_q   <= a_neg;
        sign_b_q   <= b_neg;
        div_zero_q <= in_zero;
        div_ovf_q  <= in_ovf;
        dsr_q      <= b_mag;
        acc_q      <= {{WIDTH{1'b0}}, a_mag};
        cnt_q      <= '0;
        if (early)
          result_o <= early_res;
      end else if ((state_q == MD_MUL) || (state_q == MD_DIV)) begin
        acc_q <= acc_step;
        cnt_q <= cnt_q + CW'(1);
      end else if ((state_q == MD_FIXUP) && !flush_i) begin
        result_o <= fix_res;
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: a 32/1 instance for the main function and a
// 32/4 instance for the faster iteration setting.
module tb_ex_muldiv;

  localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010,
                         F_MULHU = 3'b011, F_DIV = 3'b100, F_DIVU = 3'b101,
                         F_REM = 3'b110, F_REMU = 3'b111;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start1 = 1'b0, start4 = 1'b0;
  logic [2:0]  op_i = '0;
  logic [31:0] a_i = '0, b_i = '0;
  logic        flush_i = 1'b0;
  logic        stall1, done1, stall4, done4;
  logic [31:0] res1, res4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ex_muldiv #(.WIDTH(32), .BITS_PER_CYCLE(1), .EARLY_OUT(1'b1)) dut (
    .clk(clk), .rst(rst), .start_i(start1), .op_i(op_i), .a_i(a_i), .b_i(b_i),
    .flush_i(flush_i), .stall_o(stall1), .done_o(done1), .result_o(res1)
  );

  ex_muldiv #(.WIDTH(32), .BITS_PER_CYCLE(4), .EARLY_OUT(1'b1)) dut_b4 (
    .clk(clk), .rst(rst), .start_i(start4), .op_i(op_i), .a_i(a_i), .b_i(b_i),
    .flush_i(flush_i), .stall_o(stall4), .done_o(done4), .result_o(res4)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Runs one op with start held until done (as the pipeline would), checking
  // latency, result, stall coverage and the single-cycle done pulse.
  task automatic do_op(input string tag, input bit sel, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input int exp_lat);
    int   lat;
    int   stall_bad;
    logic d, s;
    @(negedge clk);
    op_i = op; a_i = a; b_i = b;
    if (sel) start4 = 1'b1; else start1 = 1'b1;
    #1;
    s = sel ? stall4 : stall1;
    check_eq({tag, ".stall_c0"}, 64'(s), 64'd1);
    lat = 0; stall_bad = 0; d = 1'b0;
    while (!d && lat < 200) begin
      @(negedge clk);
      lat++;
      d = sel ? done4 : done1;
      s = sel ? stall4 : stall1;
      if (!d && !s) stall_bad++;
    end
    start1 = 1'b0; start4 = 1'b0;
    check_eq({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    check_eq({tag, ".result"}, 64'(sel ? res4 : res1), 64'(exp_res));
    check_eq({tag, ".stall_done"}, 64'(s), 64'd0);
    check_eq({tag, ".stall_gaps"}, 64'(stall_bad), 64'd0);
    @(negedge clk);
    check_eq({tag, ".done_pulse"}, 64'(sel ? done4 : done1), 64'd0);
  endtask

  initial begin
    int seen_done;
    #2;
    check_eq("rst.stall", 64'(stall1), 64'd0);
    check_eq("rst.done", 64'(done1), 64'd0);
    check_eq("rst.result", 64'(res1), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    do_op("mul_7x-3",   1'b0, F_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34);
    do_op("mulh_min",   1'b0, F_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 34);
    do_op("mulhu_ff",   1'b0, F_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34);
    do_op("mulhsu_ff",  1'b0, F_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34);
    do_op("div_-7_2",   1'b0, F_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34);
    do_op("rem_-7_2",   1'b0, F_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34);
    do_op("divu_100_7", 1'b0, F_DIVU,   32'd100,      32'd7,        32'd14,       34);

    // Flush at iteration 10 of a MUL; result must stay at 14.
    @(negedge clk);
    op_i = F_MUL; a_i = 32'd5; b_i = 32'd6; start1 = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done1) seen_done++;
    end
    flush_i = 1'b1; start1 = 1'b0;
    @(negedge clk);
    flush_i = 1'b0;
    if (done1) seen_done++;
    check_eq("flush.stall", 64'(stall1), 64'd0);
    check_eq("flush.result", 64'(res1), 64'd14);
    for (int i = 0; i < 3; i++) begin
      #1;
      if (done1) seen_done++;
      @(negedge clk);
    end
    check_eq("flush.no_done", 64'(seen_done), 64'd0);
    do_op("mul_3x4", 1'b0, F_MUL, 32'd3, 32'd4, 32'd12, 34);

    do_op("remu_100_7", 1'b0, F_REMU, 32'd100, 32'd7, 32'd2, 34);

    do_op("divu_5_0",  1'b0, F_DIVU, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
    do_op("rem_5_0",   1'b0, F_REM,  32'd5,        32'd0,        32'd5,        1);
    do_op("div_ovf",   1'b0, F_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    do_op("rem_ovf",   1'b0, F_REM,  32'h80000000, 32'hFFFFFFFF, 32'd0,        1);

    // Flush and start together in IDLE: not accepted.
    @(negedge clk);
    op_i = F_MUL; a_i = 32'd9; b_i = 32'd9; start1 = 1'b1; flush_i = 1'b1;
    #1;
    check_eq("fl_start.stall_c0", 64'(stall1), 64'd0);
    @(negedge clk);
    start1 = 1'b0; flush_i = 1'b0;
    #1;
    check_eq("fl_start.not_taken", 64'(stall1), 64'd0);
    check_eq("fl_start.result", 64'(res1), 64'd0);

    do_op("b4_div_1000_3", 1'b1, F_DIV, 32'd1000, 32'd3, 32'd333, 10);

    // Asynchronous reset in the middle of an iteration.
    @(negedge clk);
    op_i = F_DIVU; a_i = 32'd100; b_i = 32'd7; start1 = 1'b1;
    for (int i = 0; i < 5; i++) @(negedge clk);
    check_eq("rstmid.busy", 64'(stall1), 64'd1);
    rst = 1'b0;
    #1;
    check_eq("rstmid.stall", 64'(stall1), 64'd0);
    check_eq("rstmid.done", 64'(done1), 64'd0);
    check_eq("rstmid.result", 64'(res1), 64'd0);
    @(negedge clk);
    start1 = 1'b0;
    rst = 1'b1;
    do_op("post_rst_remu", 1'b0, F_REMU, 32'd100, 32'd7, 32'd2, 34);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
